tt_um_jtag_tap: RTL and testbench

- IEEE 1149.1-style JTAG TAP controller with a small boundary-scan chain around a trivial 4-bit core.
- Sits as a TinyTapeout user tile. JTAG pins arrive on ui_in and are oversampled by the system clock, so there is no separate TCK clock domain.
- Provides IDCODE, BYPASS, SAMPLE/PRELOAD, EXTEST and an 8-bit USER data register that drives the bidirectional pins.

---
 rtl/tt_um_jtag_tap.sv | 217 +++++++++++++++++++++
 tb/tb_tt_um_jtag_tap.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jtag_tap.sv
`timescale 1ns/1ps
// tt_um_jtag_tap: oversampled JTAG TAP with IDCODE, BYPASS, SAMPLE/PRELOAD,
// EXTEST and an 8-bit USER register, wrapped around a trivial 4-bit core.
module tt_um_jtag_tap #(
    parameter logic [31:0] IDCODE   = 32'h1A2B_3C4D,
    parameter int unsigned IR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned ID_W   = 32;
    localparam int unsigned USER_W = 8;
    localparam int unsigned BSR_W  = 8;

    localparam logic [IR_WIDTH-1:0] INSTR_EXTEST = IR_WIDTH'(0);
    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(4'b0101);

    typedef enum logic [3:0] {
        ST_TLR       = 4'h0,
        ST_RTI       = 4'h1,
        ST_SEL_DR    = 4'h2,
        ST_CAP_DR    = 4'h3,
        ST_SHIFT_DR  = 4'h4,
        ST_EXIT1_DR  = 4'h5,
        ST_PAUSE_DR  = 4'h6,
        ST_EXIT2_DR  = 4'h7,
        ST_UPD_DR    = 4'h8,
        ST_SEL_IR    = 4'h9,
        ST_CAP_IR    = 4'hA,
        ST_SHIFT_IR  = 4'hB,
        ST_EXIT1_IR  = 4'hC,
        ST_PAUSE_IR  = 4'hD,
        ST_EXIT2_IR  = 4'hE,
        ST_UPD_IR    = 4'hF
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic [3:0]          sync1_q, sync2_q;
    logic                tck_prev_q;
    logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
    logic                bypass_q;
    logic [ID_W-1:0]     idcode_sr_q;
    logic [USER_W-1:0]   user_sr_q, user_q;
    logic [BSR_W-1:0]    bsr_sr_q, bsr_upd_q;
    logic [3:0]          core_out_q;
    logic                tdo_q, tdo_en_q;

    logic tck_s, tms_s, tdi_s, trst_n_s, tck_rise, tck_fall;
    logic sel_extest, sel_idcode, sel_sample, sel_user, sel_bsr, sel_bypass;
    logic dr_so, serial_out, ir_path;
    logic [3:0] pins_out;
    logic unused_ok;

    assign tck_s    = sync2_q[0];
    assign tms_s    = sync2_q[1];
    assign tdi_s    = sync2_q[2];
    assign trst_n_s = sync2_q[3];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    assign sel_extest = (ir_q == INSTR_EXTEST);
    assign sel_idcode = (ir_q == INSTR_IDCODE);
    assign sel_sample = (ir_q == INSTR_SAMPLE);
    assign sel_user   = (ir_q == INSTR_USER);
    assign sel_bsr    = sel_extest | sel_sample;
    assign sel_bypass = ~(sel_bsr | sel_idcode | sel_user);

    // Two-flop synchronizer on the JTAG pins plus a history flop for TCK edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            sync1_q    <= ui_in[3:0];
            sync2_q    <= sync1_q;
            tck_prev_q <= sync2_q[0];
        end
    end

    // TAP state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_TLR;
        else        state_q <= state_d;
    end

    // TAP next-state: standard 1149.1 graph stepped on each TCK rise
    always_comb begin
        state_d = state_q;
        if (!trst_n_s) begin
            state_d = ST_TLR;
        end else if (tck_rise) begin
            case (state_q)
                ST_TLR:      state_d = tms_s ? ST_TLR      : ST_RTI;
                ST_RTI:      state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                ST_SEL_DR:   state_d = tms_s ? ST_SEL_IR   : ST_CAP_DR;
                ST_CAP_DR:   state_d = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_SHIFT_DR: state_d = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_EXIT1_DR: state_d = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
                ST_PAUSE_DR: state_d = tms_s ? ST_EXIT2_DR : ST_PAUSE_DR;
                ST_EXIT2_DR: state_d = tms_s ? ST_UPD_DR   : ST_SHIFT_DR;
                ST_UPD_DR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                ST_SEL_IR:   state_d = tms_s ? ST_TLR      : ST_CAP_IR;
                ST_CAP_IR:   state_d = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_SHIFT_IR: state_d = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_EXIT1_IR: state_d = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
                ST_PAUSE_IR: state_d = tms_s ? ST_EXIT2_IR : ST_PAUSE_IR;
                ST_EXIT2_IR: state_d = tms_s ? ST_UPD_IR   : ST_SHIFT_IR;
                ST_UPD_IR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                default:     state_d = ST_TLR;
            endcase
        end
    end

    // Instruction register: capture/shift on TCK rise, update on TCK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_sr_q <= '0;
            ir_q    <= INSTR_IDCODE;
        end else if (!trst_n_s) begin
            ir_sr_q <= '0;
            ir_q    <= INSTR_IDCODE;
        end else begin
            if (state_q == ST_TLR) ir_q <= INSTR_IDCODE;
            if (tck_rise && state_q == ST_CAP_IR)   ir_sr_q <= IR_CAPTURE;
            if (tck_rise && state_q == ST_SHIFT_IR) ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
            if (tck_fall && state_q == ST_UPD_IR)   ir_q    <= ir_sr_q;
        end
    end

    // Data register shift stages: only the register picked by the IR moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
            user_sr_q   <= '0;
            bsr_sr_q    <= '0;
        end else if (!trst_n_s) begin
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
            user_sr_q   <= '0;
            bsr_sr_q    <= '0;
        end else if (tck_rise) begin
            if (state_q == ST_CAP_DR) begin
                if (sel_bypass) bypass_q    <= 1'b0;
                if (sel_idcode) idcode_sr_q <= IDCODE;
                if (sel_user)   user_sr_q   <= user_q;
                if (sel_bsr)    bsr_sr_q    <= {core_out_q, ui_in[7:4]};
            end else if (state_q == ST_SHIFT_DR) begin
                if (sel_bypass) bypass_q    <= tdi_s;
                if (sel_idcode) idcode_sr_q <= {tdi_s, idcode_sr_q[ID_W-1:1]};
                if (sel_user)   user_sr_q   <= {tdi_s, user_sr_q[USER_W-1:1]};
                if (sel_bsr)    bsr_sr_q    <= {tdi_s, bsr_sr_q[BSR_W-1:1]};
            end
        end
    end

    // Update latches: USER and boundary survive TRST, only rst_n clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            user_q    <= '0;
            bsr_upd_q <= '0;
        end else if (trst_n_s && tck_fall && state_q == ST_UPD_DR) begin
            if (sel_user) user_q    <= user_sr_q;
            if (sel_bsr)  bsr_upd_q <= bsr_sr_q;
        end
    end

    // Serial-out selection between the IR and the active DR
    always_comb begin
        dr_so = bypass_q;
        if (sel_idcode)    dr_so = idcode_sr_q[0];
        else if (sel_user) dr_so = user_sr_q[0];
        else if (sel_bsr)  dr_so = bsr_sr_q[0];
        ir_path    = state_q inside {ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR,
                                     ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR};
        serial_out = ir_path ? ir_sr_q[0] : dr_so;
    end

    // TDO and its enable change on TCK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (!trst_n_s) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (tck_fall) begin
            tdo_q    <= serial_out;
            tdo_en_q <= (state_q == ST_SHIFT_IR) || (state_q == ST_SHIFT_DR);
        end
    end

    // Core: registered copy of its input, fed by the boundary latch in EXTEST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_out_q <= '0;
        else        core_out_q <= sel_extest ? bsr_upd_q[3:0] : ui_in[7:4];
    end

    assign pins_out  = sel_extest ? bsr_upd_q[7:4] : core_out_q;
    assign uo_out    = {pins_out, 2'b00, tdo_en_q, tdo_q};
    assign uio_out   = user_q;
    assign uio_oe    = 8'hFF;
    assign unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_jtag_tap.sv
`timescale 1ns/1ps
// Directed plus randomized bench for tt_um_jtag_tap against a scan-level model.
module tb_tt_um_jtag_tap;

    localparam logic [31:0] IDCODE = 32'h1A2B_3C4D;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    int         total = 0;
    int         bad   = 0;

    // Model of architectural state
    logic [3:0] m_ir, m_pins;
    logic [7:0] m_user, m_latch;

    always #5 clk = ~clk;

    tt_um_jtag_tap dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TCK period; TDO/enable are sampled just before the rising edge
    task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo, output logic en);
        ui_in[1] = tms;
        ui_in[2] = tdi;
        repeat (6) @(negedge clk);
        tdo = uo_out[0];
        en  = uo_out[1];
        ui_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        ui_in[0] = 1'b0;
    endtask

    task automatic tms_step(input logic tms);
        logic t, e;
        tck_pulse(tms, 1'b0, t, e);
    endtask

    task automatic set_pins(input logic [3:0] v);
        ui_in[7:4] = v;
        m_pins     = v;
    endtask

    function automatic logic [3:0] exp_pins();
        return (m_ir == 4'h0) ? m_latch[7:4] : m_pins;
    endfunction

    // Selected DR length and captured value, straight from the instruction table
    task automatic dr_model(output int len, output logic [31:0] cap);
        case (m_ir)
            4'h0:    begin len = 8;  cap = {24'h0, m_latch[3:0], m_pins}; end
            4'h2:    begin len = 8;  cap = {24'h0, m_pins, m_pins}; end
            4'h1:    begin len = 32; cap = IDCODE; end
            4'h3:    begin len = 8;  cap = {24'h0, m_user}; end
            default: begin len = 1;  cap = 32'h0; end
        endcase
    endtask

    // Shift-out stream: captured bits first, then TDI delayed by the length
    function automatic logic [63:0] exp_shift(input logic [31:0] cap, input int len,
                                              input logic [63:0] din, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < len) ? cap[i] : din[i - len];
        return r;
    endfunction

    function automatic logic [31:0] final_val(input int len, input logic [63:0] din, input int n);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < len; j++) r[j] = din[n - len + j];
        return r;
    endfunction

    // From Run-Test/Idle: load an IR value, return the captured IR bits
    task automatic scan_ir(input logic [3:0] val, output logic [3:0] cap);
        logic t, e;
        tms_step(1'b1); tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_pulse(i == 3, val[i], t, e);
            cap[i] = t;
        end
        tms_step(1'b1); tms_step(1'b0);
        m_ir = val;
    endtask

    task automatic ir_load(input string tag, input logic [3:0] val);
        logic [3:0] cap;
        scan_ir(val, cap);
        check({tag, "_ircap"}, 64'(cap), 64'h5);
    endtask

    // From Run-Test/Idle: full DR scan of n bits back to Run-Test/Idle
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic en_all, output logic en_after);
        logic t, e;
        dout   = '0;
        en_all = 1'b1;
        tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < n; i++) begin
            tck_pulse(i == n - 1, din[i], t, e);
            dout[i] = t;
            en_all  = en_all & e;
        end
        tck_pulse(1'b1, 1'b0, t, e);
        en_after = e;
        tms_step(1'b0);
    endtask

    task automatic do_dr(input string tag, input int extra, input logic [63:0] din);
        int          len, n;
        logic [31:0] cap, fin;
        logic [63:0] dout, exp;
        logic        en_all, en_after;
        dr_model(len, cap);
        n   = len + extra;
        exp = exp_shift(cap, len, din, n);
        scan_dr(n, din, dout, en_all, en_after);
        check({tag, "_tdo"}, dout, exp);
        check({tag, "_en"}, 64'(en_all), 64'd1);
        check({tag, "_en_after"}, 64'(en_after), 64'd0);
        fin = final_val(len, din, n);
        if (m_ir == 4'h3) m_user = fin[7:0];
        else if (m_ir == 4'h0 || m_ir == 4'h2) m_latch = fin[7:0];
        repeat (4) @(negedge clk);
        check({tag, "_uio"}, 64'(uio_out), 64'(m_user));
        check({tag, "_pins"}, 64'(uo_out[7:4]), 64'(exp_pins()));
    endtask

    task automatic goto_shift_dr_and_shift(input int k);
        tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < k; i++) tms_step(1'b0);
    endtask

    task automatic tap_reset();
        for (int i = 0; i < 5; i++) tms_step(1'b1);
        tms_step(1'b0);
        m_ir = 4'h1;
    endtask

    initial begin
        logic [3:0] ir_pick;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h08;
        rst_n  = 1'b0;
        m_ir = 4'h1; m_pins = 4'h0; m_user = 8'h00; m_latch = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uo", 64'(uo_out), 64'h00);
        check("rst_uio", 64'(uio_out), 64'h00);
        check("rst_oe", 64'(uio_oe), 64'hFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // IDCODE straight after reset
        tap_reset();
        check("idle_en", 64'(uo_out[1]), 64'd0);
        do_dr("idcode", 0, {$urandom, $urandom});

        // IR capture pattern, then BYPASS one-bit delay
        ir_load("byp", 4'hF);
        do_dr("byp", 3, 64'b1101);

        // USER write and readback
        ir_load("user", 4'h3);
        do_dr("user_wr", 0, 64'hA5);
        check("user_oe", 64'(uio_oe), 64'hFF);
        do_dr("user_rd", 0, {$urandom, $urandom});

        // SAMPLE/PRELOAD with pins 1001, preloading 0x60
        set_pins(4'b1001);
        repeat (4) @(negedge clk);
        ir_load("sample", 4'h2);
        do_dr("sample", 0, 64'h60);

        // EXTEST drives the latch onto the pins regardless of ui_in
        ir_load("extest", 4'h0);
        check("extest_pins", 64'(uo_out[7:4]), 64'h6);
        for (int i = 0; i < 4; i++) begin
            set_pins(4'($urandom));
            repeat (3) @(negedge clk);
            check("extest_hold", 64'(uo_out[7:4]), 64'h6);
        end
        tap_reset();
        repeat (4) @(negedge clk);
        check("tlr_pins", 64'(uo_out[7:4]), 64'(m_pins));
        do_dr("tlr_idcode", 0, {$urandom, $urandom});

        // Randomized IR/DR traffic
        for (int it = 0; it < 25; it++) begin
            set_pins(4'($urandom));
            case ($urandom_range(0, 5))
                0:       ir_pick = 4'h0;
                1:       ir_pick = 4'h1;
                2:       ir_pick = 4'h2;
                3:       ir_pick = 4'h3;
                4:       ir_pick = 4'hF;
                default: ir_pick = 4'($urandom);
            endcase
            ir_load("rnd", ir_pick);
            do_dr("rnd", int'($urandom_range(0, 3)), {$urandom, $urandom});
        end

        // Asynchronous reset in the middle of a DR shift
        set_pins(4'hA);
        ir_load("rstmid", 4'h3);
        do_dr("rstmid", 0, 64'h3C);
        goto_shift_dr_and_shift(2);
        check("rstmid_shift_en", 64'(uo_out[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_uo", 64'(uo_out), 64'h00);
        check("rstmid_uio", 64'(uio_out), 64'h00);
        check("rstmid_oe", 64'(uio_oe), 64'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        m_ir = 4'h1; m_user = 8'h00; m_latch = 8'h00;
        repeat (4) @(negedge clk);
        tap_reset();
        do_dr("post_rst", 0, {$urandom, $urandom});

        // TRST_n in the middle of a DR shift keeps USER
        ir_load("trst", 4'h3);
        do_dr("trst", 0, 64'($urandom));
        goto_shift_dr_and_shift(2);
        check("trst_shift_en", 64'(uo_out[1]), 64'd1);
        ui_in[3] = 1'b0;
        repeat (6) @(negedge clk);
        check("trst_en", 64'(uo_out[1]), 64'd0);
        check("trst_uio", 64'(uio_out), 64'(m_user));
        ui_in[3] = 1'b1;
        m_ir = 4'h1;
        repeat (4) @(negedge clk);
        tms_step(1'b0);
        do_dr("post_trst", 0, {$urandom, $urandom});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
